// File: rtl/fetch_pkt_sender_if.sv
// fetch_pkt_sender_if: icache request/response and fetch-buffer push bundle.
// master: the sender drives the icache request and the buffer push fields.
// slave:  the icache/buffer side drives the response, allowin and pop_en.
interface fetch_pkt_sender_if;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [31:0] icache_raddr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst0;
    logic [31:0] icache_resp_inst1;
    logic [31:0] icache_resp_badv;
    logic [6:0]  icache_resp_exception;
    logic [1:0]  icache_resp_excp_flag;
    logic        fifo_allowin;
    logic        pop_en;
    logic        fifo_readygo;
    logic [31:0] if1_fifo_inst0;
    logic [31:0] if1_fifo_inst1;
    logic [31:0] if1_fifo_pc;
    logic [31:0] if1_fifo_pc_next;
    logic [1:0]  if1_fifo_pc_taken;
    logic [31:0] if1_fifo_icache_badv;
    logic [6:0]  if1_fifo_icache_exception;
    logic [1:0]  if1_fifo_icache_excp_flag;
    logic [1:0]  priv_flag;
    logic [1:0]  branch_flag;
    modport master (
        output icache_req_valid, icache_raddr, fifo_readygo,
               if1_fifo_inst0, if1_fifo_inst1, if1_fifo_pc, if1_fifo_pc_next,
               if1_fifo_pc_taken, if1_fifo_icache_badv, if1_fifo_icache_exception,
               if1_fifo_icache_excp_flag, priv_flag, branch_flag,
        input  icache_req_ready, icache_resp_valid, icache_resp_inst0, icache_resp_inst1,
               icache_resp_badv, icache_resp_exception, icache_resp_excp_flag,
               fifo_allowin, pop_en
    );
    modport slave (
        input  icache_req_valid, icache_raddr, fifo_readygo,
               if1_fifo_inst0, if1_fifo_inst1, if1_fifo_pc, if1_fifo_pc_next,
               if1_fifo_pc_taken, if1_fifo_icache_badv, if1_fifo_icache_exception,
               if1_fifo_icache_excp_flag, priv_flag, branch_flag,
        output icache_req_ready, icache_resp_valid, icache_resp_inst0, icache_resp_inst1,
               icache_resp_badv, icache_resp_exception, icache_resp_excp_flag,
               fifo_allowin, pop_en
    );
endinterface

// File: rtl/fetch_pkt_sender.sv
// fetch_pkt_sender: credit-based IF1 fetch PC generator and fetch-buffer packet pusher.
// Ports: clk; rstn (synchronous, active-high); flush/flush_target redirect;
// bp_taken/bp_slot/bp_target prediction; bus (icache + fetch buffer, master);
// perf_push_cnt/perf_nocredit_cnt counters, live only with FETCH_PERF_CNT_EN defined.
module fetch_pkt_sender #(
    parameter logic [31:0] PC_RESET  = 32'h1c000000,
    parameter int          BUF_DEPTH = 2,
    parameter int          MAX_OUTST = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic [31:0]        flush_target,
    input  logic               bp_taken,
    input  logic               bp_slot,
    input  logic [31:0]        bp_target,
    fetch_pkt_sender_if.master bus,
    output logic [31:0]        perf_push_cnt,
    output logic [31:0]        perf_nocredit_cnt
);
    localparam int CW = $clog2(BUF_DEPTH + MAX_OUTST + 1);
    localparam int QW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
    typedef enum logic {RUN, HALT} state_t;
    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, pc_next;
    logic [CW-1:0] occ, outst, drop_cnt;
    logic [31:0]   q_pc [MAX_OUTST];
    logic [31:0]   q_pc_next [MAX_OUTST];
    logic [1:0]    q_taken [MAX_OUTST];
    logic [QW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    pc_taken, priv, branch;
    logic          has_credit, issue, push, pop, stop;

    function automatic logic is_priv(input logic [31:0] i);
        return i[31:24] == 8'h04 || i[31:23] == 9'b000001100;
    endfunction

    function automatic logic [QW-1:0] wrap_inc(input logic [QW-1:0] p);
        return p == QW'(MAX_OUTST - 1) ? '0 : p + QW'(1);
    endfunction

    // Issue only when a buffer slot is already reserved for the response.
    assign has_credit = (occ + outst) < CW'(BUF_DEPTH);
    assign bus.icache_req_valid = !rstn && state == RUN && has_credit && outst < CW'(MAX_OUTST) && !flush;
    assign bus.icache_raddr = {fetch_pc[31:3], 3'b000};
    assign issue = bus.icache_req_valid && bus.icache_req_ready;
    // Entry into the odd word has no valid slot 0, so a slot-0 prediction is not recorded.
    assign pc_taken = bp_taken ? {bp_slot, !bp_slot && !fetch_pc[2]} : 2'b00;
    assign pc_next = bp_taken ? bp_target : {fetch_pc[31:3] + 29'd1, 3'b000};
    // Responses to requests issued before a flush are counted off by drop_cnt.
    assign push = !rstn && bus.icache_resp_valid && drop_cnt == '0 && !flush;
    assign pop = bus.pop_en && occ != '0;
    assign priv = {is_priv(bus.icache_resp_inst1), is_priv(bus.icache_resp_inst0)};
    assign branch = {bus.icache_resp_inst1[31:30] == 2'b01, bus.icache_resp_inst0[31:30] == 2'b01};
    assign stop = push && (bus.icache_resp_excp_flag != 2'b00 || priv != 2'b00);

    assign bus.fifo_readygo = push;
    assign bus.if1_fifo_inst0 = push ? bus.icache_resp_inst0 : '0;
    assign bus.if1_fifo_inst1 = push ? bus.icache_resp_inst1 : '0;
    assign bus.if1_fifo_pc = push ? q_pc[rd_ptr] : '0;
    assign bus.if1_fifo_pc_next = push ? q_pc_next[rd_ptr] : '0;
    assign bus.if1_fifo_pc_taken = push ? q_taken[rd_ptr] : '0;
    assign bus.if1_fifo_icache_badv = push ? bus.icache_resp_badv : '0;
    assign bus.if1_fifo_icache_exception = push ? bus.icache_resp_exception : '0;
    assign bus.if1_fifo_icache_excp_flag = push ? bus.icache_resp_excp_flag : '0;
    assign bus.priv_flag = push ? priv : '0;
    assign bus.branch_flag = push ? branch : '0;

    always_ff @(posedge clk) begin
        state <= rstn ? RUN : state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = flush ? RUN : stop ? HALT : state;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            fetch_pc <= PC_RESET;
            occ      <= '0;
            outst    <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            outst <= outst + CW'(issue) - CW'(bus.icache_resp_valid);
            if (flush) begin
                fetch_pc <= flush_target;
                occ      <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                drop_cnt <= outst - CW'(bus.icache_resp_valid);
            end else begin
                occ <= occ + CW'(push) - CW'(pop);
                if (bus.icache_resp_valid && drop_cnt != '0)
                    drop_cnt <= drop_cnt - CW'(1);
                if (issue) begin
                    fetch_pc          <= pc_next;
                    q_pc[wr_ptr]      <= fetch_pc;
                    q_pc_next[wr_ptr] <= pc_next;
                    q_taken[wr_ptr]   <= pc_taken;
                    wr_ptr            <= wrap_inc(wr_ptr);
                end
                if (push)
                    rd_ptr <= wrap_inc(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            assert (bus.fifo_allowin);
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rstn) begin
            perf_push_cnt     <= '0;
            perf_nocredit_cnt <= '0;
        end else begin
            if (push && perf_push_cnt != '1)
                perf_push_cnt <= perf_push_cnt + 32'd1;
            if (state == RUN && !has_credit && !flush && perf_nocredit_cnt != '1)
                perf_nocredit_cnt <= perf_nocredit_cnt + 32'd1;
        end
    end
`else
    assign perf_push_cnt = '0;
    assign perf_nocredit_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_pkt_sender.sv
// tb_fetch_pkt_sender: directed bench for fetch_pkt_sender with hand-computed expectations.
module tb_fetch_pkt_sender;
    logic        clk = 0;
    logic        rstn, flush, bp_taken, bp_slot;
    logic [31:0] flush_target, bp_target, perf_push_cnt, perf_nocredit_cnt;
    int          n_chk = 0, n_pass = 0, n_fail = 0;

    fetch_pkt_sender_if bus();

    fetch_pkt_sender dut (
        .clk(clk), .rstn(rstn), .flush(flush), .flush_target(flush_target),
        .bp_taken(bp_taken), .bp_slot(bp_slot), .bp_target(bp_target),
        .bus(bus), .perf_push_cnt(perf_push_cnt), .perf_nocredit_cnt(perf_nocredit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
        flush = 0;
        bp_taken = 0;
        bp_slot = 0;
        bus.pop_en = 0;
        bus.icache_resp_valid = 0;
        bus.icache_resp_badv = 0;
        bus.icache_resp_exception = 0;
        bus.icache_resp_excp_flag = 0;
    endtask

    task automatic resp(input logic [31:0] i0, input logic [31:0] i1);
        bus.icache_resp_valid = 1;
        bus.icache_resp_inst0 = i0;
        bus.icache_resp_inst1 = i1;
    endtask

    task automatic pkt(input string tag, input logic [31:0] pc, input logic [31:0] pcn, input logic [1:0] tk);
        chk({tag, "_go"}, bus.fifo_readygo, 1);
        chk({tag, "_pc"}, bus.if1_fifo_pc, pc);
        chk({tag, "_pcnext"}, bus.if1_fifo_pc_next, pcn);
        chk({tag, "_taken"}, bus.if1_fifo_pc_taken, tk);
    endtask

    task automatic req(input string tag, input logic v, input logic [31:0] a);
        chk({tag, "_rv"}, bus.icache_req_valid, v);
        if (v) chk({tag, "_raddr"}, bus.icache_raddr, a);
    endtask

    initial begin
        rstn = 1; flush = 0; flush_target = 0; bp_taken = 0; bp_slot = 0; bp_target = 0;
        bus.icache_req_ready = 1; bus.fifo_allowin = 1; bus.pop_en = 0;
        bus.icache_resp_valid = 0; bus.icache_resp_inst0 = 0; bus.icache_resp_inst1 = 0;
        bus.icache_resp_badv = 0; bus.icache_resp_exception = 0; bus.icache_resp_excp_flag = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rv", bus.icache_req_valid, 0);
        chk("rst_raddr", bus.icache_raddr, 32'h1c000000);
        chk("rst_go", bus.fifo_readygo, 0);
        chk("rst_perf_push", perf_push_cnt, 0);
        // A: first request
        next(); rstn = 0; #1;
        req("a", 1, 32'h1c000000);
        // B: response for 1c000000, predicted-taken slot 1 on the 1c000008 request
        next(); resp(32'h00000001, 32'h00000002); bp_taken = 1; bp_slot = 1; bp_target = 32'h1c000100; #1;
        pkt("b", 32'h1c000000, 32'h1c000008, 2'b00);
        chk("b_inst0", bus.if1_fifo_inst0, 32'h00000001);
        chk("b_inst1", bus.if1_fifo_inst1, 32'h00000002);
        chk("b_flags", {28'd0, bus.priv_flag, bus.branch_flag}, 0);
        req("b", 1, 32'h1c000008);
        // C: predicted packet pushed; occ=1 outst=1 leaves no credit
        next(); resp(32'h3, 32'h4); bus.pop_en = 1; #1;
        pkt("c", 32'h1c000008, 32'h1c000100, 2'b10);
        req("c", 0, 0);
        next(); bus.pop_en = 1; #1;
        chk("d_go", bus.fifo_readygo, 0);
        req("d", 1, 32'h1c000100);
        // E/F: stop popping, two pushes fill the buffer
        next(); resp(32'h5, 32'h6); #1;
        pkt("e", 32'h1c000100, 32'h1c000108, 2'b00);
        req("e", 1, 32'h1c000108);
        next(); resp(32'h7, 32'h8); #1;
        pkt("f", 32'h1c000108, 32'h1c000110, 2'b00);
        req("f", 0, 0);
        next(); #1;
        req("g", 0, 0);
        chk("g_go", bus.fifo_readygo, 0);
        next(); #1;
        req("h", 0, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("h_perf_nocredit", perf_nocredit_cnt, 3);
        chk("h_perf_push", perf_push_cnt, 4);
`else
        chk("h_perf_nocredit", perf_nocredit_cnt, 0);
        chk("h_perf_push", perf_push_cnt, 0);
`endif
        // One pop buys exactly one request
        next(); bus.pop_en = 1; #1;
        req("i", 0, 0);
        next(); #1;
        req("j", 1, 32'h1c000110);
        next(); #1;
        req("k", 0, 0);
        next(); bus.pop_en = 1; #1;
        req("l", 0, 0);
        next(); #1;
        req("m", 1, 32'h1c000118);
        // Flush with two requests in flight
        next(); flush = 1; flush_target = 32'h1c008000; #1;
        req("n", 0, 0);
        chk("n_go", bus.fifo_readygo, 0);
        next(); resp(32'h9, 32'ha); #1;
        chk("o_drop_go", bus.fifo_readygo, 0);
        req("o", 0, 0);
        next(); resp(32'hb, 32'hc); #1;
        chk("p_drop_go", bus.fifo_readygo, 0);
        req("p", 1, 32'h1c008000);
        next(); bus.icache_req_ready = 0; #1;
        req("q_occ0", 1, 32'h1c008008);
        // Exception response halts fetch
        next(); resp(32'h0, 32'h0); bus.icache_resp_badv = 32'h1c000010;
        bus.icache_resp_exception = 7'h08; bus.icache_resp_excp_flag = 2'b01; #1;
        pkt("r", 32'h1c008000, 32'h1c008008, 2'b00);
        chk("r_badv", bus.if1_fifo_icache_badv, 32'h1c000010);
        chk("r_exc", bus.if1_fifo_icache_exception, 7'h08);
        chk("r_flag", bus.if1_fifo_icache_excp_flag, 2'b01);
        next(); bus.icache_req_ready = 1; #1;
        req("s_halt", 0, 0);
        next(); #1;
        req("t_halt", 0, 0);
        // Flush into the odd word with a slot-0 prediction
        next(); flush = 1; flush_target = 32'h1c00c004; #1;
        req("u", 0, 0);
        next(); bp_taken = 1; bp_slot = 0; bp_target = 32'h1c00c200; #1;
        req("v", 1, 32'h1c00c000);
        next(); bus.icache_req_ready = 0; resp(32'h04000000, 32'h4c000020); #1;
        pkt("w", 32'h1c00c004, 32'h1c00c200, 2'b00);
        chk("w_priv", bus.priv_flag, 2'b01);
        chk("w_branch", bus.branch_flag, 2'b10);
        req("w", 1, 32'h1c00c200);
        next(); #1;
        req("x_halt", 0, 0);
        // Reset in the middle of activity
        next(); rstn = 1; resp(32'h1, 32'h2); #1;
        chk("y_go", bus.fifo_readygo, 0);
        req("y", 0, 0);
        next(); rstn = 0; bus.icache_req_ready = 1; #1;
        req("z", 1, 32'h1c000000);
        chk("z_go", bus.fifo_readygo, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_pkt_sender.md
Name: fetch_pkt_sender

Overview:
- Producer side of the IF1-to-decode fetch buffer.
- Generates fetch PCs and issues 2-instruction (8-byte) requests to the icache.
- Pairs in-order icache responses with the PC/prediction metadata it kept for each request, predecodes flags, and pushes packets into the fetch buffer.
- Guarantees no push is lost: a request is issued only when a buffer slot is already reserved for its response (credit scheme).

Parameters:
- PC_RESET, 32'h1c000000, fetch PC after reset.
- BUF_DEPTH, 2, fetch-buffer capacity in packets; must equal the buffer's depth.
- MAX_OUTST, 2, maximum icache requests in flight (1..4).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous reset, **active-high**; the name is kept per project convention.
- flush  in  1  redirect from backend; also flushes the fetch buffer in the same cycle.
- flush_target  in  32  new fetch PC on flush.
- bp_taken  in  1  predictor says the current packet contains a taken branch.
- bp_slot  in  1  slot (0/1) of the predicted-taken branch.
- bp_target  in  32  predicted target.
- icache_req_valid  out  1  request strobe.
- icache_req_ready  in  1  icache accepts the request.
- icache_raddr  out  32  request address, 8-byte aligned.
- icache_resp_valid  in  1  response strobe; responses return in request order.
- icache_resp_inst0, icache_resp_inst1  in  32 each  response instructions.
- icache_resp_badv  in  32  faulting address.
- icache_resp_exception  in  7  exception code.
- icache_resp_excp_flag  in  2  nonzero = exception.
- fifo_allowin  in  1  buffer not full (sanity only).
- pop_en  in  1  buffer popped this cycle (credit return).
- fifo_readygo  out  1  push strobe.
- if1_fifo_inst0, if1_fifo_inst1, if1_fifo_pc, if1_fifo_pc_next  out  32 each.
- if1_fifo_pc_taken  out  2.
- if1_fifo_icache_badv  out  32.
- if1_fifo_icache_exception  out  7.
- if1_fifo_icache_excp_flag  out  2.
- priv_flag, branch_flag  out  2 each  per-slot predecode.

Behaviour:

Reset:
- fetch_pc=PC_RESET, occ=0, outst=0, drop_cnt=0, state=RUN, meta queue empty.
- All outputs 0, except icache_raddr=PC_RESET.

Credits:
- credit = BUF_DEPTH - occ - outst.
- icache_req_valid = (state==RUN) && credit>0 && outst<MAX_OUTST && !flush.
- icache_raddr = {fetch_pc[31:3],3'b0}.

Issue (icache_req_valid && icache_req_ready):
- outst+1.
- Push {pc=fetch_pc, pc_next, pc_taken} to the meta queue (depth MAX_OUTST, circular, wrap at MAX_OUTST).
- pc_taken = bp_taken ? (bp_slot ? 2'b10 : 2'b01) : 2'b00.
- pc_next = bp_taken ? bp_target : {fetch_pc[31:3]+1,3'b000}. This 32-bit add wraps modulo 2^32.
- fetch_pc <= pc_next.
- If fetch_pc[2]==1 (entry into odd word), pc_taken bit0 is forced 0 and slot 0 is still carried; decode ignores it.

Response (icache_resp_valid):
- outst-1; pop the meta queue head.
- If drop_cnt>0: drop_cnt-1, no push.
- Otherwise fifo_readygo=1 in the same cycle (combinational). Data fields come from the response, pc/pc_next/pc_taken from the queue head. occ+1.

Predecode, per slot i:
- branch_flag[i] = inst[31:30]==2'b01.
- priv_flag[i] = inst[31:24]==8'h04 || inst[31:23]==9'b000001100.

Counter updates:
- occ: +push -pop_en; simultaneous push and pop leave occ unchanged.
- outst: issue and response in the same cycle leave it unchanged; the meta queue pushes and pops both.

States:
- RUN -> HALT when a pushed packet has excp_flag!=0 or priv_flag!=0. No further issue; responses already in flight are still pushed.
- HALT -> RUN only on flush.

Flush (highest priority):
- fetch_pc<=flush_target, occ<=0, state<=RUN, meta queue cleared.
- drop_cnt <= outst minus a response arriving this cycle. That response is itself not pushed.
- No request is issued in the flush cycle.
- Requests still outstanding at flush are dropped when they return.

Error check:
- A push while fifo_allowin==0 is a design error; assert in simulation.

Reset during activity:
- Everything returns to reset values. The icache is reset in the same cycle.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: 32-bit saturating counters perf_push_cnt (pushes) and perf_nocredit_cnt (cycles in RUN with credit==0, no flush). Extra outputs of the same names; cleared by rstn, not by flush.
- Undefined: the counter logic is absent and both outputs are tied to 0.

Test Plan:
1. Reset, req_ready=1, 1-cycle response latency, pop_en=1 every cycle -> icache_raddr issues 1c000000, 1c000008, 1c000010; pushes carry pc_next = pc+8 and pc_taken=00.
2. No pops, responses immediate -> exactly 2 pushes, then icache_req_valid=0 with perf_nocredit_cnt incrementing; one pop_en re-enables exactly one request.
3. bp_taken=1, bp_slot=1, bp_target=1c000100 on the request at 1c000008 -> that push has pc_taken=10 and pc_next=1c000100; the next raddr is 1c000100.
4. Two requests outstanding, flush with flush_target=1c008000 -> both returning responses dropped (no fifo_readygo); the next raddr is 1c008000; occ=0.
5. Response with excp_flag=01, exception=7'h08, badv=1c000010 -> pushed with those values; state HALT, no requests until flush.
6. inst0=32'h04000000 (CSR op) -> priv_flag=01 and HALT; inst1=32'h4c000020 -> branch_flag=10.
